fx_div: RTL and testbench

Sequential signed Q16.16 fixed-point divider, the inverse of the filter datapath's fixed-point multiplier. It produces one quotient bit per clock by restoring division on operand magnitudes, then applies sign and saturation. It sits beside the multiplier in the digital filter, serving gain normalisation and coefficient scaling. It uses a start/busy/done handshake rather than a fixed cycle slot.

---
 rtl/fx_div.sv | 176 +++++++++++++++++
 tb/tb_fx_div.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fx_div.sv
// Sequential signed Q(WIDTH-FRAC).FRAC divider: restoring division on operand
// magnitudes, one quotient bit per clock, then sign restore and saturation.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// DIV   | one restoring-division iteration per cycle, WIDTH+FRAC total
// SIGN  | apply sign, saturate, register outputs and pulse done
module fx_div #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int NW = WIDTH + FRAC;
  localparam int CW = $clog2(NW);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NW-1:0]    Q_POS_LIMIT = {{FRAC{1'b0}}, SAT_MAX};
  localparam logic [NW-1:0]    Q_NEG_LIMIT = {{FRAC{1'b0}}, SAT_MIN};
  localparam logic [CW-1:0]    LAST_ITER   = CW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SIGN
  } state_t;

  state_t state, state_next;

  logic             neg;
  logic             zero_div;
  logic             dvd_neg;
  logic [NW-1:0]    n_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   rem;
  logic [NW-1:0]    q_reg;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH:0]   rem_sub;

  logic [WIDTH-1:0] q_low;
  logic [WIDTH-1:0] q_final;
  logic             ovf_final;

  // Magnitudes: the most negative value maps onto itself, which is exactly
  // its magnitude when read as unsigned.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign rem_shift = (rem << 1) | {{WIDTH{1'b0}}, n_reg[NW-1]};
  assign rem_ge    = (rem_shift >= {1'b0, d_reg});
  assign rem_sub   = rem_shift - {1'b0, d_reg};

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor_mag == '0) ? SIGN : DIV;
        end
      end
      DIV: begin
        if (cnt == LAST_ITER) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sign restore and saturation of the unsigned magnitude quotient.
  always_comb begin
    q_low     = q_reg[WIDTH-1:0];
    q_final   = q_low;
    ovf_final = 1'b0;
    if (zero_div) begin
      q_final = dvd_neg ? SAT_MIN : SAT_MAX;
    end else if (!neg) begin
      if (q_reg > Q_POS_LIMIT) begin
        q_final   = SAT_MAX;
        ovf_final = 1'b1;
      end
    end else begin
      if (q_reg > Q_NEG_LIMIT) begin
        q_final   = SAT_MIN;
        ovf_final = 1'b1;
      end else begin
        q_final = -q_low;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      neg         <= 1'b0;
      zero_div    <= 1'b0;
      dvd_neg     <= 1'b0;
      n_reg       <= '0;
      d_reg       <= '0;
      rem         <= '0;
      q_reg       <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            neg         <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dvd_neg     <= dividend[WIDTH-1];
            zero_div    <= (divisor_mag == '0);
            n_reg       <= {dividend_mag, {FRAC{1'b0}}};
            d_reg       <= divisor_mag;
            rem         <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        DIV: begin
          n_reg <= {n_reg[NW-2:0], 1'b0};
          rem   <= rem_ge ? rem_sub : rem_shift;
          q_reg <= {q_reg[NW-2:0], rem_ge};
          cnt   <= cnt + CW'(1);
        end
        SIGN: begin
          quotient    <= q_final;
          div_by_zero <= zero_div;
          overflow    <= ovf_final;
          done        <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_div.sv
// Directed and randomized checks of fx_div: latency, handshake, saturation,
// divide-by-zero and reset abort, with a queue of expected results.
module tb_fx_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        overflow;

  typedef struct {
    logic [31:0] q;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fx_div #(.WIDTH(32), .FRAC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] q, input logic dbz, input logic ovf);
    exp_t e;
    e.q = q; e.dbz = dbz; e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Independent reference: 64-bit signed arithmetic, C-style truncation.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint num, r, maxv, minv;
    maxv = 64'sd2147483647;
    minv = -maxv - 1;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 32'd0) begin
      e.q   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.dbz = 1'b1;
    end else begin
      num = longint'($signed(a)) * 65536;
      r   = num / longint'($signed(b));
      if (r > maxv) begin
        e.q = 32'h7FFF_FFFF; e.ovf = 1'b1;
      end else if (r < minv) begin
        e.q = 32'h8000_0000; e.ovf = 1'b1;
      end else begin
        e.q = r[31:0];
      end
    end
    return e;
  endfunction

  // Ends at the falling edge right after the edge that samples start.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input bit pulses);
    int   lat;
    int   bcnt;
    bit   got;
    exp_t e;
    lat = 0; bcnt = 0; got = 1'b0;
    while (lat < 200) begin
      if (busy) bcnt++;
      if (pulses) begin
        if (lat == 5 || lat == 20 || lat == 40) begin
          start    = 1'b1;
          dividend = $urandom;
          divisor  = $urandom;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (pulses) start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_lat);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
    end
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check({tag, "_extra_done"}, seen, 0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic dbz, input logic ovf, input int lat);
    push(q, dbz, ovf);
    start_op(a, b, 1'b0);
    wait_result(tag, lat, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    exp_t        e;

    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b1;

    directed("basic",     32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 1'b0, 49);
    @(negedge clk);
    check("done_pulse_width", {31'd0, done}, 32'd0);
    directed("neg3_by_1p5", 32'hFFFD_0000, 32'h0001_8000, 32'hFFFE_0000, 1'b0, 1'b0, 49);
    directed("third",     32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 49);
    directed("neg_third", 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 49);
    directed("sat_pos",   32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 49);
    directed("sat_min_neg1", 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 49);
    directed("exact_min", 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49);
    directed("neg_zero",  32'hFFFF_FFFF, 32'h7FFF_0000, 32'h0000_0000, 1'b0, 1'b0, 49);
    directed("dbz_neg",   32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
    directed("dbz_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    directed("flags_clear", 32'h0003_0000, 32'hFFFF_0000, 32'hFFFD_0000, 1'b0, 1'b0, 49);

    // starts during busy are ignored; operands scrambled after acceptance
    push(32'h0000_8000, 1'b0, 1'b0);
    start_op(32'h0001_0000, 32'h0002_0000, 1'b0);
    wait_result("ignored_starts", 49, 1'b1);
    no_done_for("ignored_starts", 60);

    // start held high through done: second division accepted in the done cycle
    push(32'h0000_5555, 1'b0, 1'b0);
    start_op(32'h0001_0000, 32'h0003_0000, 1'b1);
    wait_result("hold_first", 49, 1'b0);
    dividend = 32'hFFFD_0000;
    divisor  = 32'h0001_8000;
    push(32'hFFFE_0000, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_result("hold_second", 49, 1'b0);

    // mid-operation reset after iteration 20 aborts without a done
    start_op(32'h0005_0000, 32'h0002_0000, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    no_done_for("abort", 60);
    directed("after_abort", 32'h0004_0000, 32'h0002_0000, 32'h0002_0000, 1'b0, 1'b0, 49);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 24);
      e  = model(ra, rb);
      push(e.q, e.dbz, e.ovf);
      start_op(ra, rb, 1'b0);
      wait_result("random", (rb == 32'd0) ? 1 : 49, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
